// File: rtl/rv_defs_pkg.sv
// Shared RV32I definitions for the single-cycle execute core.
// Holds the opcode constants, the ALU opcode enum, the next-PC and
// write-back select encodings, and helpers that map funct3 onto ALU ops.
// No ports. Optional feature macro used by the core: RV32M_EN.
package rv_defs_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } aluOp_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } origPc_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_PC4  = 2'b01,
    WB_LOAD = 2'b10
  } mem2Reg_t;

  // Base integer op from funct3; alt (instr bit 30) turns ADD into SUB
  // and SRL into SRA. The caller decides whether alt is meaningful.
  function automatic aluOp_t baseAluOp(input logic [2:0] funct3, input logic alt);
    aluOp_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Multiply/divide op from funct3 for the M extension encodings.
  function automatic aluOp_t mulDivAluOp(input logic [2:0] funct3);
    aluOp_t op;
    op = ALU_MUL;
    case (funct3)
      3'b000: op = ALU_MUL;
      3'b001: op = ALU_MULH;
      3'b010: op = ALU_MULHSU;
      3'b011: op = ALU_MULHU;
      3'b100: op = ALU_DIV;
      3'b101: op = ALU_DIVU;
      3'b110: op = ALU_REM;
      3'b111: op = ALU_REMU;
      default: op = ALU_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uni_alu.sv
// Combinational ALU for the single-cycle core.
// Ports: a, b (32-bit operands), op (ALU opcode), result (32-bit).
// Macro RV32M_EN: when defined, the multiply/divide opcodes are implemented;
// otherwise they fall through to a zero result like any unknown opcode.
module uni_alu
  import rv_defs_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  aluOp_t      op,
  output logic [31:0] result
);

`ifdef RV32M_EN
  logic        mulSignedA;
  logic        mulSignedB;
  logic [63:0] product;
  logic        divSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  // One 64-bit multiplier serves all four multiply ops: each operand is
  // sign- or zero-extended to 64 bits first, so the low 64 bits of the
  // product are correct for every signedness combination.
  assign mulSignedA = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign mulSignedB = (op == ALU_MULH);
  assign product    = {{32{mulSignedA & a[31]}}, a} * {{32{mulSignedB & b[31]}}, b};

  // Signed divide is done on magnitudes with one unsigned divider and the
  // sign fixed afterwards. This also makes 0x80000000 / -1 come out as
  // 0x80000000 with remainder 0 without a special case.
  assign divSigned = (op == ALU_DIV) || (op == ALU_REM);
  assign dividend  = (divSigned && a[31]) ? (32'd0 - a) : a;
  assign divisor   = (divSigned && b[31]) ? (32'd0 - b) : b;
  assign divByZero = (b == 32'd0);
  assign quotMag   = divByZero ? 32'd0 : dividend / divisor;
  assign remMag    = divByZero ? 32'd0 : dividend % divisor;
  assign quotient  = (divSigned && (a[31] ^ b[31])) ? (32'd0 - quotMag) : quotMag;
  assign remainder = (divSigned && a[31]) ? (32'd0 - remMag) : remMag;
`endif

  // Operation select; shifts only look at the low five bits of b.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_PASSB: result = b;
`ifdef RV32M_EN
      ALU_MUL:    result = product[31:0];
      ALU_MULH:   result = product[63:32];
      ALU_MULHSU: result = product[63:32];
      ALU_MULHU:  result = product[63:32];
      ALU_DIV:    result = divByZero ? 32'hFFFF_FFFF : quotient;
      ALU_DIVU:   result = divByZero ? 32'hFFFF_FFFF : quotient;
      ALU_REM:    result = divByZero ? a : remainder;
      ALU_REMU:   result = divByZero ? a : remainder;
`endif
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/uni_exec_core.sv
// Single-cycle RV32I control/execute core: instruction decode, datapath
// strobes, ALU, branch compare and the PC register.
// Ports:
//   iCLK, iRST            clock and synchronous active-high reset
//   iInitialPC            PC loaded while iRST is high
//   iInstr                current instruction
//   iRead1, iRead2, iImm  rs1, rs2 and sign-extended immediate
//   oPC, oPC4             current PC and PC+4
//   oALUResult, oZero     ALU result (also data address) and its zero flag
//   oBranch               branch condition from rs1 vs rs2 under funct3
//   oOrigAULA, oOrigBULA  ALU operand selects (PC / immediate)
//   oMem2Reg              write-back select
//   oRegWrite, oMemRead, oMemWrite  enables
//   oALUControl           ALU opcode
//   oOrigPC               next-PC select
// Macro RV32M_EN: enables the multiply/divide decode and ALU ops.
module uni_exec_core
  import rv_defs_pkg::*;
#(
  parameter logic [31:0] BEGINNING_TEXT = 32'h0040_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInitialPC,
  input  logic [31:0] iInstr,
  input  logic [31:0] iRead1,
  input  logic [31:0] iRead2,
  input  logic [31:0] iImm,
  output logic [31:0] oPC,
  output logic [31:0] oPC4,
  output logic [31:0] oALUResult,
  output logic        oZero,
  output logic        oBranch,
  output logic        oOrigAULA,
  output logic        oOrigBULA,
  output logic [1:0]  oMem2Reg,
  output logic        oRegWrite,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [4:0]  oALUControl,
  output logic [1:0]  oOrigPC
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pcReg = BEGINNING_TEXT;
  logic [31:0] nextPC;
  logic [31:0] aluA;
  logic [31:0] aluB;
  aluOp_t      aluCtl;
  origPc_t     origPc;
  mem2Reg_t    mem2Reg;
  logic        origA;
  logic        origB;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        branchTaken;
  logic        unusedInstrBits;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];

  // Register indices are consumed by the register file, not here.
  assign unusedInstrBits = ^{iInstr[24:15], iInstr[11:7]};

  // Main decoder: every strobe starts inactive so unlisted opcodes (and
  // M encodings in a build without the M extension) behave as NOPs.
  always_comb begin
    origA    = 1'b0;
    origB    = 1'b0;
    mem2Reg  = WB_ALU;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    aluCtl   = ALU_ADD;
    origPc   = PC_PLUS4;
    case (opcode)
      OPC_R: begin
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EN
          regWrite = 1'b1;
          aluCtl   = mulDivAluOp(funct3);
`endif
        end else begin
          regWrite = 1'b1;
          aluCtl   = baseAluOp(funct3, iInstr[30]);
        end
      end
      OPC_I_ALU: begin
        // Bit 30 is part of the immediate except for SRAI.
        origB    = 1'b1;
        regWrite = 1'b1;
        aluCtl   = baseAluOp(funct3, (funct3 == 3'b101) && iInstr[30]);
      end
      OPC_LOAD: begin
        origB    = 1'b1;
        memRead  = 1'b1;
        mem2Reg  = WB_LOAD;
        regWrite = 1'b1;
      end
      OPC_STORE: begin
        origB    = 1'b1;
        memWrite = 1'b1;
      end
      OPC_BRANCH: begin
        aluCtl = ALU_SUB;
        origPc = PC_BRANCH;
      end
      OPC_JAL: begin
        mem2Reg  = WB_PC4;
        regWrite = 1'b1;
        origPc   = PC_JAL;
      end
      OPC_JALR: begin
        mem2Reg  = WB_PC4;
        regWrite = 1'b1;
        origPc   = PC_JALR;
      end
      OPC_LUI: begin
        origB    = 1'b1;
        aluCtl   = ALU_PASSB;
        regWrite = 1'b1;
      end
      OPC_AUIPC: begin
        origA    = 1'b1;
        origB    = 1'b1;
        regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition always compares the raw register values; only the
  // next-PC select decides whether it matters.
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = (iRead1 == iRead2);
      3'b001:  branchTaken = (iRead1 != iRead2);
      3'b100:  branchTaken = ($signed(iRead1) < $signed(iRead2));
      3'b101:  branchTaken = ($signed(iRead1) >= $signed(iRead2));
      3'b110:  branchTaken = (iRead1 < iRead2);
      3'b111:  branchTaken = (iRead1 >= iRead2);
      default: branchTaken = 1'b0;
    endcase
  end

  assign aluA = origA ? pcReg : iRead1;
  assign aluB = origB ? iImm : iRead2;

  uni_alu alu (
    .a      (aluA),
    .b      (aluB),
    .op     (aluCtl),
    .result (oALUResult)
  );

  // Next-PC mux; JALR clears bit 0 of the computed target.
  always_comb begin
    nextPC = pcReg + 32'd4;
    case (origPc)
      PC_PLUS4:  nextPC = pcReg + 32'd4;
      PC_BRANCH: nextPC = branchTaken ? (pcReg + iImm) : (pcReg + 32'd4);
      PC_JAL:    nextPC = pcReg + iImm;
      PC_JALR:   nextPC = (iRead1 + iImm) & ~32'd1;
      default:   nextPC = pcReg + 32'd4;
    endcase
  end

  // PC register: reset wins over whatever instruction is presented.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pcReg <= iInitialPC;
    end else begin
      pcReg <= nextPC;
    end
  end

  assign oPC         = pcReg;
  assign oPC4        = pcReg + 32'd4;
  assign oZero       = (oALUResult == 32'd0);
  assign oBranch     = branchTaken;
  assign oOrigAULA   = origA;
  assign oOrigBULA   = origB;
  assign oMem2Reg    = mem2Reg;
  assign oRegWrite   = regWrite;
  assign oMemRead    = memRead;
  assign oMemWrite   = memWrite;
  assign oALUControl = aluCtl;
  assign oOrigPC     = origPc;

endmodule

// File: tb/tb_uni_exec_core.sv
// Self-checking bench for uni_exec_core: directed cases for reset, ALU,
// branches, jumps and memory strobes, then randomized instructions checked
// against an instruction-level reference model.
// Macro RV32M_EN: also exercises the multiply/divide encodings.
module tb_uni_exec_core;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iInitialPC;
  logic [31:0] iInstr;
  logic [31:0] iRead1;
  logic [31:0] iRead2;
  logic [31:0] iImm;
  logic [31:0] oPC;
  logic [31:0] oPC4;
  logic [31:0] oALUResult;
  logic        oZero;
  logic        oBranch;
  logic        oOrigAULA;
  logic        oOrigBULA;
  logic [1:0]  oMem2Reg;
  logic        oRegWrite;
  logic        oMemRead;
  logic        oMemWrite;
  logic [4:0]  oALUControl;
  logic [1:0]  oOrigPC;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] modelPC;

  typedef struct packed {
    logic [31:0] alu;
    logic        br;
    logic        origA;
    logic        origB;
    logic [1:0]  m2r;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  ctl;
    logic [1:0]  sel;
    logic [31:0] next;
  } expect_t;

  uni_exec_core dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iInitialPC  (iInitialPC),
    .iInstr      (iInstr),
    .iRead1      (iRead1),
    .iRead2      (iRead2),
    .iImm        (iImm),
    .oPC         (oPC),
    .oPC4        (oPC4),
    .oALUResult  (oALUResult),
    .oZero       (oZero),
    .oBranch     (oBranch),
    .oOrigAULA   (oOrigAULA),
    .oOrigBULA   (oOrigBULA),
    .oMem2Reg    (oMem2Reg),
    .oRegWrite   (oRegWrite),
    .oMemRead    (oMemRead),
    .oMemWrite   (oMemWrite),
    .oALUControl (oALUControl),
    .oOrigPC     (oOrigPC)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Integer instruction semantics (R and I-ALU share them).
  function automatic logic [31:0] intResult(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [4:0] intCode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 5'd1 : 5'd0;
      3'd1: return 5'd5;
      3'd2: return 5'd8;
      3'd3: return 5'd9;
      3'd4: return 5'd4;
      3'd5: return alt ? 5'd7 : 5'd6;
      3'd6: return 5'd3;
      default: return 5'd2;
    endcase
  endfunction

  // M-extension semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] mulDivResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint r;
    logic [63:0] u64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin r = sa * sb; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin u64 = {32'd0, a} * {32'd0, b}; return u64[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        r = ua / ub;
        return r[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        r = sa % sb;
        return r[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        r = ua % ub;
        return r[31:0];
      end
    endcase
  endfunction

  function automatic expect_t refModel(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] imm, input logic [31:0] pc);
    expect_t e;
    logic [2:0] f3;
    f3 = instr[14:12];
    e = '0;
    e.alu = a + b;
    case (f3)
      3'd0: e.br = (a == b);
      3'd1: e.br = (a != b);
      3'd4: e.br = ($signed(a) < $signed(b));
      3'd5: e.br = !($signed(a) < $signed(b));
      3'd6: e.br = (a < b);
      3'd7: e.br = !(a < b);
      default: e.br = 1'b0;
    endcase
    case (instr[6:0])
      7'h33: begin
        if (instr[31:25] == 7'h01) begin
`ifdef RV32M_EN
          e.rw  = 1'b1;
          e.ctl = 5'd11 + {2'd0, f3};
          e.alu = mulDivResult(f3, a, b);
`endif
        end else begin
          e.rw  = 1'b1;
          e.ctl = intCode(f3, instr[30]);
          e.alu = intResult(f3, instr[30], a, b);
        end
      end
      7'h13: begin
        e.origB = 1'b1;
        e.rw    = 1'b1;
        e.ctl   = intCode(f3, (f3 == 3'd5) && instr[30]);
        e.alu   = intResult(f3, (f3 == 3'd5) && instr[30], a, imm);
      end
      7'h03: begin e.origB = 1'b1; e.mr = 1'b1; e.m2r = 2'b10; e.rw = 1'b1; e.alu = a + imm; end
      7'h23: begin e.origB = 1'b1; e.mw = 1'b1; e.alu = a + imm; end
      7'h63: begin e.ctl = 5'd1; e.alu = a - b; e.sel = 2'b01; end
      7'h6F: begin e.m2r = 2'b01; e.rw = 1'b1; e.sel = 2'b10; end
      7'h67: begin e.m2r = 2'b01; e.rw = 1'b1; e.sel = 2'b11; end
      7'h37: begin e.origB = 1'b1; e.rw = 1'b1; e.ctl = 5'd10; e.alu = imm; end
      7'h17: begin e.origA = 1'b1; e.origB = 1'b1; e.rw = 1'b1; e.alu = pc + imm; end
      default: ;
    endcase
    case (e.sel)
      2'b01:   e.next = e.br ? pc + imm : pc + 32'd4;
      2'b10:   e.next = pc + imm;
      2'b11:   e.next = (a + imm) & 32'hFFFF_FFFE;
      default: e.next = pc + 32'd4;
    endcase
    return e;
  endfunction

  // Drive one instruction on the falling edge, check every combinational
  // output before the rising edge, then check the PC after it.
  task automatic applyStimulus(input string name, input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic rst, input logic [31:0] initPC);
    expect_t e;
    @(negedge iCLK);
    iInstr     = instr;
    iRead1     = a;
    iRead2     = b;
    iImm       = imm;
    iRST       = rst;
    iInitialPC = initPC;
    e = refModel(instr, a, b, imm, modelPC);
    #1;
    checkOutput({name, ".pc"},       oPC, modelPC);
    checkOutput({name, ".pc4"},      oPC4, modelPC + 32'd4);
    checkOutput({name, ".alu"},      oALUResult, e.alu);
    checkOutput({name, ".zero"},     32'(oZero), 32'(e.alu == 32'd0));
    checkOutput({name, ".branch"},   32'(oBranch), 32'(e.br));
    checkOutput({name, ".origA"},    32'(oOrigAULA), 32'(e.origA));
    checkOutput({name, ".origB"},    32'(oOrigBULA), 32'(e.origB));
    checkOutput({name, ".mem2reg"},  32'(oMem2Reg), 32'(e.m2r));
    checkOutput({name, ".regWrite"}, 32'(oRegWrite), 32'(e.rw));
    checkOutput({name, ".memRead"},  32'(oMemRead), 32'(e.mr));
    checkOutput({name, ".memWrite"}, 32'(oMemWrite), 32'(e.mw));
    checkOutput({name, ".aluCtl"},   32'(oALUControl), 32'(e.ctl));
    checkOutput({name, ".origPC"},   32'(oOrigPC), 32'(e.sel));
    @(posedge iCLK);
    #1;
    modelPC = rst ? initPC : e.next;
    checkOutput({name, ".nextPC"}, oPC, modelPC);
  endtask

  logic [6:0] opcodeTable [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};

  initial begin
    logic [31:0] pcBefore;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  f7;
    iRST       = 1'b1;
    iInitialPC = 32'h0040_0000;
    iInstr     = 32'd0;
    iRead1     = 32'd0;
    iRead2     = 32'd0;
    iImm       = 32'd0;
    #1;
    checkOutput("powerUpPC", oPC, 32'h0040_0000);
    modelPC = 32'h0040_0000;

    applyStimulus("reset", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0040_0000);
    checkOutput("resetPC", oPC, 32'h0040_0000);

    pcBefore = modelPC;
    applyStimulus("add", 32'h0020_81B3, 32'd5, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'd0);
    checkOutput("addResult", oALUResult, 32'hFFFF_FFFE);
    checkOutput("addRegWrite", 32'(oRegWrite), 32'd1);
    checkOutput("addMem2Reg", 32'(oMem2Reg), 32'd0);
    checkOutput("addNextPC", oPC, pcBefore + 32'd4);

    applyStimulus("resetTo10a", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0040_0010);
    applyStimulus("beqTaken", 32'h0020_8063, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0, 32'd0);
    checkOutput("beqTakenBranch", 32'(oBranch), 32'd1);
    checkOutput("beqTakenPC", oPC, 32'h0040_0008);

    applyStimulus("resetTo10b", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0040_0010);
    applyStimulus("beqNotTaken", 32'h0020_8063, 32'd9, 32'd8, 32'hFFFF_FFF8, 1'b0, 32'd0);
    checkOutput("beqNotTakenPC", oPC, 32'h0040_0014);

    applyStimulus("bltu", 32'h0020_E063, 32'hFFFF_FFFF, 32'd1, 32'd16, 1'b0, 32'd0);
    checkOutput("bltuBranch", 32'(oBranch), 32'd0);
    applyStimulus("blt", 32'h0020_C063, 32'hFFFF_FFFF, 32'd1, 32'd16, 1'b0, 32'd0);
    checkOutput("bltBranch", 32'(oBranch), 32'd1);

    applyStimulus("jalr", 32'h0000_80E7, 32'h0040_0101, 32'd0, 32'd2, 1'b0, 32'd0);
    checkOutput("jalrPC", oPC, 32'h0040_0102);
    checkOutput("jalrMem2Reg", 32'(oMem2Reg), 32'd1);

    applyStimulus("lw", 32'h0000_A183, 32'h0000_1000, 32'd0, 32'h0000_0010, 1'b0, 32'd0);
    checkOutput("lwMemRead", 32'(oMemRead), 32'd1);
    checkOutput("lwMem2Reg", 32'(oMem2Reg), 32'd2);
    checkOutput("lwAddress", oALUResult, 32'h0000_1010);

    applyStimulus("sw", 32'h0020_A023, 32'h0000_2000, 32'd7, 32'd4, 1'b0, 32'd0);
    checkOutput("swMemWrite", 32'(oMemWrite), 32'd1);
    checkOutput("swRegWrite", 32'(oRegWrite), 32'd0);

    pcBefore = modelPC;
    applyStimulus("div", 32'h0220_C1B3, 32'd7, 32'd0, 32'd0, 1'b0, 32'd0);
`ifdef RV32M_EN
    checkOutput("divByZero", oALUResult, 32'hFFFF_FFFF);
    applyStimulus("remOverflow", 32'h0220_E1B3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0);
    checkOutput("remOverflow", oALUResult, 32'd0);
`else
    checkOutput("divNopRegWrite", 32'(oRegWrite), 32'd0);
    checkOutput("divNopPC", oPC, pcBefore + 32'd4);
`endif

    // Reset must win even when a jump is presented.
    applyStimulus("resetOverJal", 32'h0000_006F, 32'd0, 32'd0, 32'h0000_0100, 1'b1, 32'h0000_1234);
    checkOutput("resetOverJalPC", oPC, 32'h0000_1234);

    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      f7    = instr[31:25];
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: ;
      endcase
      instr[31:25] = f7;
      if ($urandom_range(0, 9) != 0) instr[6:0] = opcodeTable[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom_range(0, 40);
        default: ;
      endcase
      applyStimulus("random", instr, a, b, $urandom, ($urandom_range(0, 24) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
